// File: rtl/pulse_train_gen_if.sv
// -----------------------------------------------------------------------------
// pulse_train_gen_if
//   Bundles the control and status signals between the register file (master)
//   and the pulse-train generator (slave). Clock and reset are kept outside.
//
//   master -> slave : start_i, abort_i, continuous_i, ch_en_i, pol_i,
//                     pulse_width_i, pulse_num_i, gap_us_i
//   slave -> master : data_o, trig_o, busy_o, done_o, aborted_o, pulse_cnt_o
// -----------------------------------------------------------------------------
interface pulse_train_gen_if #(
    parameter int NUM_CH  = 2,
    parameter int SER_W   = 8,
    parameter int WIDTH_W = 11,
    parameter int NUM_W   = 11,
    parameter int GAP_W   = 16
);
    logic                        start_i;
    logic                        abort_i;
    logic                        continuous_i;
    logic [NUM_CH-1:0]           ch_en_i;
    logic [NUM_CH-1:0]           pol_i;
    logic [NUM_CH*WIDTH_W-1:0]   pulse_width_i;
    logic [NUM_W-1:0]            pulse_num_i;
    logic [GAP_W-1:0]            gap_us_i;

    logic [NUM_CH*SER_W-1:0]     data_o;
    logic                        trig_o;
    logic                        busy_o;
    logic                        done_o;
    logic                        aborted_o;
    logic [NUM_W-1:0]            pulse_cnt_o;

    modport master (
        output start_i, abort_i, continuous_i, ch_en_i, pol_i,
               pulse_width_i, pulse_num_i, gap_us_i,
        input  data_o, trig_o, busy_o, done_o, aborted_o, pulse_cnt_o
    );

    modport slave (
        input  start_i, abort_i, continuous_i, ch_en_i, pol_i,
               pulse_width_i, pulse_num_i, gap_us_i,
        output data_o, trig_o, busy_o, done_o, aborted_o, pulse_cnt_o
    );
endinterface

// File: rtl/pulse_train_gen.sv
// -----------------------------------------------------------------------------
// pulse_train_gen
//   Multi-channel pulse-train generator. Each clk cycle it emits one SER_W-bit
//   serializer word per channel (bit 0 leaves the serializer first). All
//   channels share pulse count and gap; each channel has its own width,
//   enable and polarity. Supports continuous mode and abort.
//
//   clk    : single clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : pulse_train_gen_if.slave (config/control in, words/status out)
//
//   Every output is a register loaded from the decode of the *next* state, so
//   data_o/trig_o/busy_o/done_o line up with the state the FSM is entering.
// -----------------------------------------------------------------------------
module pulse_train_gen #(
    parameter int NUM_CH       = 2,
    parameter int SER_W        = 8,
    parameter int WIDTH_W      = 11,
    parameter int NUM_W        = 11,
    parameter int GAP_W        = 16,
    parameter int TICKS_PER_US = 125
) (
    input  logic              clk,
    input  logic              rst_n,
    pulse_train_gen_if.slave  bus
);

    // Words per pulse never exceed 2^WIDTH_W, so one extra bit covers P.
    localparam int P_W    = WIDTH_W + 1;
    // Holds k*SER_W + i for any word index k.
    localparam int BIT_W  = P_W + $clog2(SER_W) + 1;
    // gap_us * TICKS_PER_US without overflow.
    localparam int GCNT_W = GAP_W + $clog2(TICKS_PER_US);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PULSE,
        S_GAP,
        S_DONE
    } state_e;

    state_e                    state_q, state_d;
    logic                      start_prev_q;
    logic                      cont_q;
    logic [NUM_CH-1:0]         en_q, pol_q;
    logic [NUM_CH*WIDTH_W-1:0] width_q;
    logic [NUM_W-1:0]          num_q;
    logic [GAP_W-1:0]          gap_q;
    logic [P_W-1:0]            word_q, word_d;
    logic [GCNT_W-1:0]         gap_cnt_q, gap_cnt_d;
    logic [NUM_W-1:0]          cnt_q, cnt_d;
    logic                      aborted_q, aborted_d;
    logic [NUM_CH*SER_W-1:0]   data_q, data_d;
    logic                      trig_q, busy_q, done_q;

    // Config in effect: raw inputs while in LOAD (they are being latched at
    // the end of that cycle, yet word 0 must already be computed from them),
    // the latched copy everywhere else.
    logic                      in_load;
    logic                      cont_e;
    logic [NUM_CH-1:0]         en_e, pol_e;
    logic [NUM_CH*WIDTH_W-1:0] width_e;
    logic [NUM_W-1:0]          num_e;
    logic [GAP_W-1:0]          gap_e;

    assign in_load = (state_q == S_LOAD);
    assign cont_e  = in_load ? bus.continuous_i  : cont_q;
    assign en_e    = in_load ? bus.ch_en_i       : en_q;
    assign pol_e   = in_load ? bus.pol_i         : pol_q;
    assign width_e = in_load ? bus.pulse_width_i : width_q;
    assign num_e   = in_load ? bus.pulse_num_i   : num_q;
    assign gap_e   = in_load ? bus.gap_us_i      : gap_q;

    logic start_edge;
    assign start_edge = bus.start_i & ~start_prev_q;

    // Words per pulse: P = max(1, ceil(maxw / SER_W)) over enabled channels.
    logic [WIDTH_W-1:0] maxw;
    logic [BIT_W-1:0]   words_raw;
    logic [P_W-1:0]     p_e;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        maxw = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (en_e[c] && (width_e[c*WIDTH_W +: WIDTH_W] > maxw)) begin
                maxw = width_e[c*WIDTH_W +: WIDTH_W];
            end
        end
        words_raw = (BIT_W'(maxw) + BIT_W'(SER_W - 1)) / BIT_W'(SER_W);
        p_e       = (words_raw == '0) ? P_W'(1) : P_W'(words_raw);
    end

    logic [GCNT_W-1:0] gap_ticks;
    assign gap_ticks = GCNT_W'(gap_e) * GCNT_W'(TICKS_PER_US);

    logic           last_word;
    logic [NUM_W:0] cnt_plus;
    logic           more;

    assign last_word = (word_q == p_e - P_W'(1));
    assign cnt_plus  = {1'b0, cnt_q} + (NUM_W+1)'(1);
    // Another pulse follows the one just completed (cnt_q not yet incremented).
    assign more      = cont_e || (cnt_plus < {1'b0, num_e});

    // Next-state and counter logic.
    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        gap_cnt_d = gap_cnt_q;
        cnt_d     = cnt_q;
        aborted_d = aborted_q;

        unique case (state_q)
            S_IDLE: begin
                if (start_edge) begin
                    state_d   = S_LOAD;
                    cnt_d     = '0;
                    aborted_d = 1'b0;
                end
            end
            S_LOAD: begin
                if (bus.abort_i) begin
                    state_d   = S_DONE;
                    aborted_d = 1'b1;
                end else if ((num_e == '0) && !cont_e) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_PULSE;
                    word_d  = '0;
                end
            end
            S_PULSE: begin
                if (bus.abort_i) begin
                    // Partial pulse is not counted.
                    state_d   = S_DONE;
                    aborted_d = 1'b1;
                end else if (last_word) begin
                    if (gap_ticks != '0) begin
                        state_d   = S_GAP;
                        gap_cnt_d = gap_ticks - GCNT_W'(1);
                    end else begin
                        cnt_d = cnt_q + NUM_W'(1);
                        if (more) begin
                            state_d = S_PULSE;
                            word_d  = '0;
                        end else begin
                            state_d = S_DONE;
                        end
                    end
                end else begin
                    word_d = word_q + P_W'(1);
                end
            end
            S_GAP: begin
                if (gap_cnt_q == '0) begin
                    // Pulse is complete: it counts even if abort hits now.
                    cnt_d = cnt_q + NUM_W'(1);
                    if (bus.abort_i) begin
                        state_d   = S_DONE;
                        aborted_d = 1'b1;
                    end else if (more) begin
                        state_d = S_PULSE;
                        word_d  = '0;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q - GCNT_W'(1);
                    if (bus.abort_i) begin
                        state_d   = S_DONE;
                        aborted_d = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Serializer words for the cycle being entered; idle level is pol_c.
    logic in_pulse_d;
    assign in_pulse_d = (state_d == S_PULSE);

    always_comb begin
        data_d = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            for (int i = 0; i < SER_W; i++) begin
                data_d[c*SER_W + i] = pol_e[c] ^ (in_pulse_d && en_e[c] &&
                    ((BIT_W'(word_d) * BIT_W'(SER_W) + BIT_W'(i)) <
                     BIT_W'(width_e[c*WIDTH_W +: WIDTH_W])));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            start_prev_q <= 1'b0;
            cont_q       <= 1'b0;
            en_q         <= '0;
            pol_q        <= '0;
            width_q      <= '0;
            num_q        <= '0;
            gap_q        <= '0;
            word_q       <= '0;
            gap_cnt_q    <= '0;
            cnt_q        <= '0;
            aborted_q    <= 1'b0;
            data_q       <= '0;
            trig_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q      <= state_d;
            start_prev_q <= bus.start_i;
            word_q       <= word_d;
            gap_cnt_q    <= gap_cnt_d;
            cnt_q        <= cnt_d;
            aborted_q    <= aborted_d;
            data_q       <= data_d;
            trig_q       <= in_pulse_d && (word_d == '0);
            busy_q       <= (state_d == S_LOAD) || (state_d == S_PULSE) ||
                            (state_d == S_GAP);
            done_q       <= (state_d == S_DONE);
            if (in_load) begin
                cont_q  <= bus.continuous_i;
                en_q    <= bus.ch_en_i;
                pol_q   <= bus.pol_i;
                width_q <= bus.pulse_width_i;
                num_q   <= bus.pulse_num_i;
                gap_q   <= bus.gap_us_i;
            end
        end
    end

    assign bus.data_o      = data_q;
    assign bus.trig_o      = trig_q;
    assign bus.busy_o      = busy_q;
    assign bus.done_o      = done_q;
    assign bus.aborted_o   = aborted_q;
    assign bus.pulse_cnt_o = cnt_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
// -----------------------------------------------------------------------------
// tb_pulse_train_gen
//   Scoreboard bench. Each train's expected per-cycle outputs are derived from
//   the timeline arithmetic (period = P + G, counts = elapsed periods) and
//   queued with their absolute cycle number; a monitor on the falling edge
//   pops and compares whenever the front entry's cycle arrives.
// -----------------------------------------------------------------------------
module tb_pulse_train_gen;

    localparam int NUM_CH = 2;
    localparam int SER_W  = 8;
    localparam int WID_W  = 11;
    localparam int NUM_W  = 11;
    localparam int GAP_W  = 16;
    localparam int TICKS  = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    pulse_train_gen_if #(
        .NUM_CH(NUM_CH), .SER_W(SER_W), .WIDTH_W(WID_W), .NUM_W(NUM_W), .GAP_W(GAP_W)
    ) bus ();

    pulse_train_gen #(
        .NUM_CH(NUM_CH), .SER_W(SER_W), .WIDTH_W(WID_W), .NUM_W(NUM_W),
        .GAP_W(GAP_W), .TICKS_PER_US(TICKS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int          cyc;
        bit          chk_data;
        logic [15:0] data;
        logic        trig;
        logic        busy;
        logic        done;
        logic        aborted;
        logic [10:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    // Monitor: compares whatever the DUT presents against the queued entry.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n === 1'b1 && exp_q.size() > 0) begin
            if (exp_q[0].cyc < cyc) begin
                check("sb_order", exp_q[0].cyc, cyc);
                void'(exp_q.pop_front());
            end else if (exp_q[0].cyc == cyc) begin
                e = exp_q.pop_front();
                if (e.chk_data) check("data", bus.data_o, e.data);
                check("trig",    bus.trig_o,      e.trig);
                check("busy",    bus.busy_o,      e.busy);
                check("done",    bus.done_o,      e.done);
                check("aborted", bus.aborted_o,   e.aborted);
                check("cnt",     bus.pulse_cnt_o, e.cnt);
            end
        end
    end

    // Word k of a pulse: bit i of channel c is active while k*SER_W+i < width_c.
    function automatic logic [15:0] model_word(input int k, input logic [1:0] en,
                                               input logic [1:0] pol, input int w0, input int w1);
        logic [15:0] r;
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < 8; i++) begin
                int  w;
                bit  act;
                w   = (c == 0) ? w0 : w1;
                act = en[c] && ((k * 8 + i) < w);
                r[c*8 + i] = act ^ pol[c];
            end
        end
        return r;
    endfunction

    task automatic scramble_inputs();
        bus.continuous_i  = 1'($urandom);
        bus.ch_en_i       = 2'($urandom);
        bus.pol_i         = 2'($urandom);
        bus.pulse_width_i = 22'($urandom);
        bus.pulse_num_i   = 11'($urandom);
        bus.gap_us_i      = 16'($urandom);
    endtask

    // abort_o: cycle offset (relative to the start cycle N) at which abort_i
    // is high for one cycle, -1 for none. restart_o: offset of an extra start
    // pulse that must be ignored, -1 for none.
    task automatic run_train(input bit cont, input logic [1:0] en, input logic [1:0] pol,
                             input int w0, input int w1, input int num, input int gap,
                             input int abort_o, input int restart_o);
        int          maxw, p, g, period, d, base, pos;
        bit          ab;
        logic [15:0] idle;
        exp_t        e;

        maxw = 0;
        if (en[0] && w0 > maxw) maxw = w0;
        if (en[1] && w1 > maxw) maxw = w1;
        p      = (maxw + 7) / 8;
        if (p == 0) p = 1;
        g      = gap * TICKS;
        period = p + g;
        idle   = {{8{pol[1]}}, {8{pol[0]}}};

        if (!cont && num == 0) d = 2;
        else if (!cont)        d = 2 + num * period;
        else                   d = 1 << 30;
        ab = 1'b0;
        if (abort_o >= 1 && abort_o < d) begin
            d  = abort_o + 1;
            ab = 1'b1;
        end
        if (restart_o > d) restart_o = -1;

        @(posedge clk); #1;
        bus.continuous_i  = cont;
        bus.ch_en_i       = en;
        bus.pol_i         = pol;
        bus.pulse_width_i = {11'(w1), 11'(w0)};
        bus.pulse_num_i   = 11'(num);
        bus.gap_us_i      = 16'(gap);
        bus.abort_i       = (abort_o == 0);
        bus.start_i       = 1'b1;
        base = cyc;

        for (int o = 1; o <= d + 2; o++) begin
            e.cyc      = base + o;
            e.chk_data = (o >= 2);
            pos        = (o >= 2) ? (o - 2) % period : 0;
            e.busy     = (o < d);
            e.done     = (o == d);
            e.aborted  = ab && (o >= d);
            e.trig     = (o >= 2) && (o < d) && (pos == 0);
            if (o >= 2 && o < d && pos < p) e.data = model_word(pos, en, pol, w0, w1);
            else                            e.data = idle;
            if (o == 1)      e.cnt = '0;
            else if (o >= d) e.cnt = 11'((d - 2) / period);
            else             e.cnt = 11'((o - 2) / period);
            exp_q.push_back(e);
        end

        for (int o = 1; o <= d + 2; o++) begin
            @(posedge clk); #1;
            bus.start_i = (o == restart_o);
            bus.abort_i = (o == abort_o);
            if (o == 2) scramble_inputs();
        end
        bus.start_i = 1'b0;
        bus.abort_i = 1'b0;
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        bit  cont;
        int  num, ab_o, rs_o;

        rst_n             = 1'b0;
        bus.start_i       = 1'b0;
        bus.abort_i       = 1'b0;
        bus.continuous_i  = 1'b0;
        bus.ch_en_i       = '0;
        bus.pol_i         = '0;
        bus.pulse_width_i = '0;
        bus.pulse_num_i   = '0;
        bus.gap_us_i      = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_data",    bus.data_o,      16'h0);
        check("rst_trig",    bus.trig_o,      1'b0);
        check("rst_busy",    bus.busy_o,      1'b0);
        check("rst_done",    bus.done_o,      1'b0);
        check("rst_aborted", bus.aborted_o,   1'b0);
        check("rst_cnt",     bus.pulse_cnt_o, 11'h0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Two pulses, P=2, G=4: trig at N+2 and N+8, done at N+14.
        run_train(0, 2'b11, 2'b00, 3, 13, 2, 1, -1, -1);
        // ch1 idle-high with width 0, single back-to-back pulse.
        run_train(0, 2'b11, 2'b10, 8, 0, 1, 0, -1, -1);
        // Ignored restart at N+5, abort at N+12 -> done N+13, count 1.
        run_train(0, 2'b11, 2'b00, 3, 13, 3, 2, 12, 5);
        // Continuous, period 5, abort after 20 pulses.
        run_train(1, 2'b01, 2'b00, 8, 0, 0, 1, 102, -1);
        // Zero pulses: busy only in LOAD, done at N+2.
        run_train(0, 2'b11, 2'b00, 5, 5, 0, 1, -1, -1);
        // Abort on the last gap cycle: pulse still counted.
        run_train(0, 2'b11, 2'b01, 3, 13, 2, 1, 7, -1);
        // Abort in IDLE (start cycle) and in DONE are ignored.
        run_train(0, 2'b11, 2'b00, 3, 13, 1, 1, 0, -1);
        run_train(0, 2'b10, 2'b00, 3, 13, 1, 1, 8, -1);
        // Abort while in LOAD.
        run_train(0, 2'b11, 2'b11, 20, 4, 3, 1, 1, -1);

        for (int t = 0; t < 30; t++) begin
            cont = ($urandom_range(0, 3) == 0);
            num  = $urandom_range(0, 4);
            if (cont) ab_o = $urandom_range(1, 60);
            else      ab_o = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 50)) : -1;
            rs_o = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 12)) : -1;
            run_train(cont, 2'($urandom), 2'($urandom), $urandom_range(0, 40),
                      $urandom_range(0, 40), num, $urandom_range(0, 3), ab_o, rs_o);
        end

        // Asynchronous reset in the middle of pulse word 1.
        @(posedge clk); #1;
        bus.continuous_i  = 1'b0;
        bus.ch_en_i       = 2'b11;
        bus.pol_i         = 2'b00;
        bus.pulse_width_i = {11'd13, 11'd3};
        bus.pulse_num_i   = 11'd2;
        bus.gap_us_i      = 16'd1;
        bus.start_i       = 1'b1;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        @(posedge clk); #1;
        check("pre_rst_trig", bus.trig_o, 1'b1);
        @(posedge clk); #3;
        check("pre_rst_data", bus.data_o, 16'h1F00);
        rst_n = 1'b0;
        #1;
        check("arst_data", bus.data_o,      16'h0);
        check("arst_busy", bus.busy_o,      1'b0);
        check("arst_trig", bus.trig_o,      1'b0);
        check("arst_cnt",  bus.pulse_cnt_o, 11'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("post_rst_busy", bus.busy_o, 1'b0);
            check("post_rst_data", bus.data_o, 16'h0);
        end
        run_train(0, 2'b11, 2'b00, 3, 13, 2, 1, -1, -1);

        repeat (3) @(posedge clk);
        check("sb_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
